// File: rtl/bus_arbiter_mux.sv
// ---------------------------------------------------------------------------
// bus_arbiter_mux
//
// Registered round-robin bus multiplexer. NUM_SRC sources raise requests; a
// round-robin arbiter picks one winner, captures its word into the bus
// register, and presents it to the shared datapath bus under a valid/ready
// handshake. Back-to-back transfers are supported without a bubble cycle.
//
// Optional feature macro: BUS_LOCK_EN
//   When defined, adds src_lock. A source that is accepted while it holds both
//   src_lock and src_req keeps the bus for the next slot and the round-robin
//   pointer is not advanced.
//
// Ports
//   clock       in   rising-edge clock
//   clear       in   synchronous active-high reset
//   src_data    in   flattened source words, source i = [i*WIDTH +: WIDTH]
//   src_req     in   per-source request, held until acked
//   src_lock    in   per-source bus lock (BUS_LOCK_EN only)
//   src_ack     out  one-hot, high in the cycle the bus word is accepted
//   bus_data    out  registered bus word
//   bus_valid   out  bus_data holds an unaccepted word
//   bus_ready   in   consumer accepts bus_data this cycle
//   grant       out  one-hot owner of bus_data, 0 when !bus_valid
//   grant_idx   out  binary index of the owner
//   xfer_count  out  number of accepted transfers (wraps)
//
// FSM states (the state bit is bus_valid)
//   state | meaning
//   IDLE  | no word held, arbitrating every cycle
//   DRIVE | word held on the bus, waiting for bus_ready
// ---------------------------------------------------------------------------
module bus_arbiter_mux #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 24,
    parameter int SEL_W   = 5,
    parameter int CNT_W   = 16
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_req,
`ifdef BUS_LOCK_EN
    input  logic [NUM_SRC-1:0]       src_lock,
`endif
    output logic [NUM_SRC-1:0]       src_ack,
    output logic [WIDTH-1:0]         bus_data,
    output logic                     bus_valid,
    input  logic                     bus_ready,
    output logic [NUM_SRC-1:0]       grant,
    output logic [SEL_W-1:0]         grant_idx,
    output logic [CNT_W-1:0]         xfer_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [WIDTH-1:0]   data_d;
    logic [NUM_SRC-1:0] grant_d;
    logic [SEL_W-1:0]   idx_d;
    logic [CNT_W-1:0]   cnt_d;

    logic               accept;
    logic               lock_hold;
    logic [NUM_SRC-1:0] elig;
    logic               win_found;
    logic [SEL_W-1:0]   win_idx;
    int                 cand;

    assign bus_valid = (state_q == DRIVE);
    assign accept    = bus_valid && bus_ready;

`ifdef BUS_LOCK_EN
    assign lock_hold = accept && src_lock[grant_idx] && src_req[grant_idx];
`else
    assign lock_hold = 1'b0;
`endif

    // The source being accepted this cycle is masked so that a back-to-back
    // reload goes to a different requester.
    always_comb begin
        elig = src_req;
        if (accept) begin
            elig = src_req & ~grant;
        end
    end

    // Round-robin search: last+1, last+2, ... wrapping back to last itself.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = (int'(last_q) + k) % NUM_SRC;
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = SEL_W'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        data_d  = bus_data;
        grant_d = grant;
        idx_d   = grant_idx;
        cnt_d   = xfer_count;
        src_ack = '0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (win_found) begin
                    state_d = DRIVE;
                    data_d  = src_data[int'(win_idx)*WIDTH +: WIDTH];
                    grant_d = NUM_SRC'(1) << win_idx;
                    idx_d   = win_idx;
                    last_d  = win_idx;
                end
            end
            DRIVE: begin
                if (bus_ready) begin
                    src_ack = grant;
                    cnt_d   = xfer_count + CNT_W'(1);
                    if (lock_hold) begin
                        // Locked owner re-captures a fresh word; pointer stays.
                        data_d = src_data[int'(grant_idx)*WIDTH +: WIDTH];
                    end else if (win_found) begin
                        data_d  = src_data[int'(win_idx)*WIDTH +: WIDTH];
                        grant_d = NUM_SRC'(1) << win_idx;
                        idx_d   = win_idx;
                        last_d  = win_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // A clear in the accept cycle drops the word without acknowledging it.
        if (clear) begin
            src_ack = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= IDLE;
            last_q     <= SEL_W'(NUM_SRC - 1);
            bus_data   <= '0;
            grant      <= '0;
            grant_idx  <= '0;
            xfer_count <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            bus_data   <= data_d;
            grant      <= grant_d;
            grant_idx  <= idx_d;
            xfer_count <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_mux
//
// Self-checking bench for bus_arbiter_mux: a directed vector table, a few
// hand-written multi-cycle sequences, and a randomized run compared against
// a cycle-level reference model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_mux;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 24;
    localparam int SEL_W   = 5;
    localparam int CNT_W   = 16;

    logic                     clock = 1'b0;
    logic                     clear;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_req;
`ifdef BUS_LOCK_EN
    logic [NUM_SRC-1:0]       src_lock;
`endif
    logic [NUM_SRC-1:0]       src_ack;
    logic [WIDTH-1:0]         bus_data;
    logic                     bus_valid;
    logic                     bus_ready;
    logic [NUM_SRC-1:0]       grant;
    logic [SEL_W-1:0]         grant_idx;
    logic [CNT_W-1:0]         xfer_count;

    logic [WIDTH-1:0]         words [NUM_SRC];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) src_data[i*WIDTH +: WIDTH] = words[i];
    end

    bus_arbiter_mux #(
        .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .src_data   (src_data),
        .src_req    (src_req),
`ifdef BUS_LOCK_EN
        .src_lock   (src_lock),
`endif
        .src_ack    (src_ack),
        .bus_data   (bus_data),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .xfer_count (xfer_count)
    );

    typedef struct {
        logic               clr;
        logic [NUM_SRC-1:0] req;
        logic               rdy;
        logic               e_valid;
        logic [SEL_W-1:0]   e_idx;
        logic [NUM_SRC-1:0] e_ack;
        logic [CNT_W-1:0]   e_cnt;
        logic               chk_data;
        logic [WIDTH-1:0]   e_data;
    } vec_t;

    vec_t tbl [17];

    // reference model state
    logic             m_valid;
    int               m_owner;
    int               m_last;
    logic [WIDTH-1:0] m_data;
    logic [CNT_W-1:0] m_cnt;

    function automatic logic [NUM_SRC-1:0] b(input int n);
        return NUM_SRC'(1) << n;
    endfunction

    function automatic vec_t mk(input logic clr, input logic [NUM_SRC-1:0] req,
                                input logic rdy, input logic ev, input int ei,
                                input logic [NUM_SRC-1:0] ea, input int ec,
                                input logic cd, input logic [WIDTH-1:0] ed);
        vec_t v;
        v.clr = clr; v.req = req; v.rdy = rdy; v.e_valid = ev;
        v.e_idx = SEL_W'(ei); v.e_ack = ea; v.e_cnt = CNT_W'(ec);
        v.chk_data = cd; v.e_data = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Winner = requester at smallest cyclic distance after the last winner.
    function automatic int pick(input logic [NUM_SRC-1:0] e, input int last);
        int best = -1;
        int bestd = NUM_SRC;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (e[i]) begin
                int d = (i - last - 1 + 2*NUM_SRC) % NUM_SRC;
                if (d < bestd) begin bestd = d; best = i; end
            end
        end
        return best;
    endfunction

    task automatic model_reset;
        m_valid = 1'b0; m_owner = 0; m_last = NUM_SRC-1; m_data = '0; m_cnt = '0;
    endtask

    task automatic model_step;
        logic acc;
        logic [NUM_SRC-1:0] e;
        int w;
        if (clear) begin
            model_reset();
        end else begin
            acc = m_valid && bus_ready;
            if (acc) m_cnt = m_cnt + 1'b1;
            if (!m_valid || acc) begin
                w = -1;
`ifdef BUS_LOCK_EN
                if (acc && src_lock[m_owner] && src_req[m_owner]) w = m_owner;
`endif
                if (w < 0) begin
                    e = src_req;
                    if (acc) e[m_owner] = 1'b0;
                    w = pick(e, m_last);
                    if (w >= 0) m_last = w;
                end
                if (w >= 0) begin
                    m_valid = 1'b1; m_owner = w; m_data = words[w];
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic model_compare;
        logic [NUM_SRC-1:0] e_ack;
        e_ack = (m_valid && bus_ready && !clear) ? b(m_owner) : '0;
        chk("rnd_valid", 64'(bus_valid), 64'(m_valid));
        chk("rnd_grant", 64'(grant), 64'(m_valid ? b(m_owner) : '0));
        chk("rnd_ack", 64'(src_ack), 64'(e_ack));
        chk("rnd_cnt", 64'(xfer_count), 64'(m_cnt));
        chk("rnd_data", 64'(bus_data), 64'(m_data));
        if (m_valid) chk("rnd_idx", 64'(grant_idx), 64'(m_owner));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] held;
        logic [NUM_SRC-1:0] rq;

        for (int i = 0; i < NUM_SRC; i++) words[i] = 32'hA500_0000 | WIDTH'(i);
        words[3]  = 32'hDEAD_BEEF;
        src_req   = '0;
        bus_ready = 1'b0;
        clear     = 1'b1;
`ifdef BUS_LOCK_EN
        src_lock  = '0;
`endif
        tick();
        chk("reset_idx", 64'(grant_idx), 64'd0);
        chk("reset_grant", 64'(grant), 64'd0);

        rq = b(2) | b(7) | b(20);
        tbl[0]  = mk(1, '0,          0, 0, 0,  '0,    0, 1, '0);
        tbl[1]  = mk(0, b(0)|b(5),   0, 0, 0,  '0,    0, 1, '0);
        tbl[2]  = mk(0, b(0)|b(5),   0, 1, 0,  '0,    0, 1, 32'hA500_0000);
        tbl[3]  = mk(0, b(0)|b(5),   1, 1, 0,  b(0),  0, 0, '0);
        tbl[4]  = mk(0, b(5),        1, 1, 5,  b(5),  1, 1, 32'hA500_0005);
        tbl[5]  = mk(0, '0,          0, 0, 0,  '0,    2, 0, '0);
        tbl[6]  = mk(0, b(3),        1, 0, 0,  '0,    2, 0, '0);
        tbl[7]  = mk(0, b(3),        1, 1, 3,  b(3),  2, 1, 32'hDEAD_BEEF);
        tbl[8]  = mk(0, '0,          1, 0, 0,  '0,    3, 0, '0);
        tbl[9]  = mk(1, '0,          0, 0, 0,  '0,    3, 0, '0);
        tbl[10] = mk(0, rq,          1, 0, 0,  '0,    0, 0, '0);
        tbl[11] = mk(0, rq,          1, 1, 2,  b(2),  0, 1, 32'hA500_0002);
        tbl[12] = mk(0, rq,          1, 1, 7,  b(7),  1, 0, '0);
        tbl[13] = mk(0, rq,          1, 1, 20, b(20), 2, 1, 32'hA500_0014);
        tbl[14] = mk(0, rq,          1, 1, 2,  b(2),  3, 0, '0);
        tbl[15] = mk(0, '0,          0, 1, 7,  '0,    4, 0, '0);
        tbl[16] = mk(1, '0,          0, 1, 7,  '0,    4, 0, '0);

        for (int r = 0; r < 17; r++) begin
            clear = tbl[r].clr; src_req = tbl[r].req; bus_ready = tbl[r].rdy;
            @(negedge clock);
            chk($sformatf("tbl%0d_valid", r), 64'(bus_valid), 64'(tbl[r].e_valid));
            chk($sformatf("tbl%0d_ack", r), 64'(src_ack), 64'(tbl[r].e_ack));
            chk($sformatf("tbl%0d_cnt", r), 64'(xfer_count), 64'(tbl[r].e_cnt));
            chk($sformatf("tbl%0d_grant", r), 64'(grant),
                64'(tbl[r].e_valid ? b(int'(tbl[r].e_idx)) : '0));
            if (tbl[r].e_valid)
                chk($sformatf("tbl%0d_idx", r), 64'(grant_idx), 64'(tbl[r].e_idx));
            if (tbl[r].chk_data)
                chk($sformatf("tbl%0d_data", r), 64'(bus_data), 64'(tbl[r].e_data));
            tick();
        end

        // Stall: owner 4 held while its data changes and source 1 requests.
        clear = 1'b0; src_req = b(4); bus_ready = 1'b0;
        tick();
        held = words[4];
        for (int c = 0; c < 5; c++) begin
            words[4] = $urandom; src_req = b(4) | b(1);
            @(negedge clock);
            chk("stall_valid", 64'(bus_valid), 64'd1);
            chk("stall_data", 64'(bus_data), 64'(held));
            chk("stall_idx", 64'(grant_idx), 64'd4);
            chk("stall_ack", 64'(src_ack), 64'd0);
            tick();
        end
        bus_ready = 1'b1;
        @(negedge clock);
        chk("stall_release_ack", 64'(src_ack), 64'(b(4)));
        tick();
        src_req = b(1); bus_ready = 1'b0;
        @(negedge clock);
        chk("after_stall_idx", 64'(grant_idx), 64'd1);
        chk("after_stall_data", 64'(bus_data), 64'(words[1]));
        chk("after_stall_cnt", 64'(xfer_count), 64'd1);

        // Clear during an accept cycle.
        clear = 1'b1; bus_ready = 1'b1;
        @(negedge clock);
        chk("clr_accept_ack", 64'(src_ack), 64'd0);
        tick();
        clear = 1'b0; src_req = '0; bus_ready = 1'b0;
        @(negedge clock);
        chk("clr_valid", 64'(bus_valid), 64'd0);
        chk("clr_cnt", 64'(xfer_count), 64'd0);
        chk("clr_grant", 64'(grant), 64'd0);
        tick();

`ifdef BUS_LOCK_EN
        // Locked source 6 keeps the bus until the lock drops, then 9 follows.
        clear = 1'b1; tick(); clear = 1'b0;
        src_req = b(6) | b(9); src_lock = b(6); bus_ready = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) src_lock = '0;
            @(negedge clock);
            chk("lock_idx", 64'(grant_idx), 64'd6);
            chk("lock_ack", 64'(src_ack), 64'(b(6)));
            tick();
        end
        src_req = b(9);
        @(negedge clock);
        chk("lock_release_idx", 64'(grant_idx), 64'd9);
        tick();
        src_req = '0; bus_ready = 1'b0;
`endif

        // Randomized run against the reference model.
        clear = 1'b1; src_req = '0; bus_ready = 1'b0;
        model_reset();
        tick();
        for (int c = 0; c < 1500; c++) begin
            clear     = ($urandom_range(0, 49) == 0);
            src_req   = NUM_SRC'($urandom & $urandom);
            bus_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_SRC; i++) words[i] = $urandom;
`ifdef BUS_LOCK_EN
            src_lock  = NUM_SRC'($urandom & $urandom);
`endif
            @(negedge clock);
            model_compare();
            model_step();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
